// File: rtl/axi_lite_reg_bank_if.sv
// AXI-Lite bus bundle for axi_lite_reg_bank: AW, W, B, AR and R channels.
// master drives requests and accepts responses; slave is the register bank.
interface axi_lite_reg_bank_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] s_axi_awaddr;
  logic                  s_axi_awvalid;
  logic                  s_axi_awready;
  logic [DATA_WIDTH-1:0] s_axi_wdata;
  logic [STRB_W-1:0]     s_axi_wstrb;
  logic                  s_axi_wvalid;
  logic                  s_axi_wready;
  logic [1:0]            s_axi_bresp;
  logic                  s_axi_bvalid;
  logic                  s_axi_bready;
  logic [ADDR_WIDTH-1:0] s_axi_araddr;
  logic                  s_axi_arvalid;
  logic                  s_axi_arready;
  logic [DATA_WIDTH-1:0] s_axi_rdata;
  logic [1:0]            s_axi_rresp;
  logic                  s_axi_rvalid;
  logic                  s_axi_rready;

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_bready,
    output s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
    input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_bready,
    input  s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
    output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

// File: rtl/axi_lite_reg_bank.sv
// axi_lite_reg_bank: parametrised AXI-Lite slave register bank.
// AW and W are captured independently and committed together with byte enables; RO slots
// read from status_in; each RW commit raises a one-cycle wr_pulse for that register.
// Optional feature macro: AXI_LITE_ERR_EN (SLVERR for RO writes, DECERR out of range).
// Without it every response is OKAY and discarded writes are silent.
module axi_lite_reg_bank #(
  parameter int unsigned          ADDR_WIDTH = 8,
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          REG_COUNT  = 8,
  parameter logic [REG_COUNT-1:0] RO_MASK    = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  axi_lite_reg_bank_if.slave              s_axi,
  output logic [REG_COUNT*DATA_WIDTH-1:0] reg_out,
  input  logic [REG_COUNT*DATA_WIDTH-1:0] status_in,
  output logic [REG_COUNT-1:0]            wr_pulse
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = ADDR_WIDTH - 2;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  // Write-side state
  logic [IDX_W-1:0]      r_aw_idx;
  logic                  r_aw_held;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic                  r_w_held;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic [REG_COUNT-1:0]  r_wr_pulse;
  logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];

  // Read-side state
  logic                  r_rvalid;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;

  // Handshakes and decode
  logic                  w_awready;
  logic                  w_wready;
  logic                  w_arready;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_b_hs;
  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_commit;
  logic [IDX_W-1:0]      w_ar_idx;
  logic [REG_COUNT-1:0]  w_wr_sel;
  logic                  w_wr_ro;
  logic                  w_wr_oob;
  logic [1:0]            w_bresp;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_rd_oob;
  logic [1:0]            w_rresp;
  logic                  w_unused;

  // Readies depend only on registered flags, so they never combinationally follow a valid.
  assign w_awready = !r_aw_held && !r_bvalid;
  assign w_wready  = !r_w_held && !r_bvalid;
  assign w_arready = !r_rvalid;

  assign w_aw_hs  = s_axi.s_axi_awvalid && w_awready;
  assign w_w_hs   = s_axi.s_axi_wvalid && w_wready;
  assign w_b_hs   = r_bvalid && s_axi.s_axi_bready;
  assign w_ar_hs  = s_axi.s_axi_arvalid && w_arready;
  assign w_r_hs   = r_rvalid && s_axi.s_axi_rready;
  assign w_commit = r_aw_held && r_w_held && !r_bvalid;

  assign w_ar_idx = s_axi.s_axi_araddr[ADDR_WIDTH-1:2];

  // Byte-offset bits of both addresses are don't-care.
  assign w_unused = ^{s_axi.s_axi_awaddr[1:0], s_axi.s_axi_araddr[1:0]};

  assign s_axi.s_axi_awready = w_awready;
  assign s_axi.s_axi_wready  = w_wready;
  assign s_axi.s_axi_bvalid  = r_bvalid;
  assign s_axi.s_axi_bresp   = r_bresp;
  assign s_axi.s_axi_arready = w_arready;
  assign s_axi.s_axi_rvalid  = r_rvalid;
  assign s_axi.s_axi_rresp   = r_rresp;
  assign s_axi.s_axi_rdata   = r_rdata;
  assign wr_pulse            = r_wr_pulse;

  // Decode the held write index into an RW select, an RO hit or out-of-range.
  always_comb begin
    w_wr_sel = '0;
    w_wr_ro  = 1'b0;
    w_wr_oob = 1'b1;
    for (int i = 0; i < int'(REG_COUNT); i++) begin
      if (r_aw_idx == IDX_W'(i)) begin
        w_wr_oob = 1'b0;
        if (RO_MASK[i]) begin
          w_wr_ro = 1'b1;
        end else begin
          w_wr_sel[i] = 1'b1;
        end
      end
    end
  end

  // Write response code for the pending commit.
  always_comb begin
    w_bresp = RespOkay;
`ifdef AXI_LITE_ERR_EN
    if (w_wr_oob) begin
      w_bresp = RespDecErr;
    end else if (w_wr_ro) begin
      w_bresp = RespSlvErr;
    end
`endif
  end

  // Read mux: RW slots return the stored value (pre-write on a same-edge commit),
  // RO slots return the live status slice captured at the AR edge.
  always_comb begin
    w_rd_data = '0;
    w_rd_oob  = 1'b1;
    for (int i = 0; i < int'(REG_COUNT); i++) begin
      if (w_ar_idx == IDX_W'(i)) begin
        w_rd_oob  = 1'b0;
        w_rd_data = RO_MASK[i] ? status_in[i*DATA_WIDTH +: DATA_WIDTH] : r_regs[i];
      end
    end
  end

  // Read response code.
  always_comb begin
    w_rresp = RespOkay;
`ifdef AXI_LITE_ERR_EN
    if (w_rd_oob) begin
      w_rresp = RespDecErr;
    end
`endif
  end

  // Flatten register storage; RO slots are never written and stay zero.
  always_comb begin
    reg_out = '0;
    for (int i = 0; i < int'(REG_COUNT); i++) begin
      reg_out[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[i];
    end
  end

  // AW capture: latch the index, release the slot on commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_aw_held <= 1'b0;
      r_aw_idx  <= '0;
    end else if (w_aw_hs) begin
      r_aw_held <= 1'b1;
      r_aw_idx  <= s_axi.s_axi_awaddr[ADDR_WIDTH-1:2];
    end else if (w_commit) begin
      r_aw_held <= 1'b0;
    end
  end

  // W capture: latch data and strobes, release the slot on commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_w_held <= 1'b0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
    end else if (w_w_hs) begin
      r_w_held <= 1'b1;
      r_wdata  <= s_axi.s_axi_wdata;
      r_wstrb  <= s_axi.s_axi_wstrb;
    end else if (w_commit) begin
      r_w_held <= 1'b0;
    end
  end

  // B channel: raise on commit, hold response until bready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RespOkay;
    end else if (w_commit) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_bresp;
    end else if (w_b_hs) begin
      r_bvalid <= 1'b0;
    end
  end

  // Register storage: byte-lane merge on commit for the selected RW register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(REG_COUNT); i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit) begin
      for (int i = 0; i < int'(REG_COUNT); i++) begin
        for (int k = 0; k < int'(STRB_W); k++) begin
          if (w_wr_sel[i] && r_wstrb[k]) begin
            r_regs[i][8*k +: 8] <= r_wdata[8*k +: 8];
          end
        end
      end
    end
  end

  // Per-register commit strobe, one cycle wide, RW in-range targets only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= w_commit ? w_wr_sel : '0;
    end
  end

  // R channel: capture data on AR handshake, hold until rready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rresp  <= RespOkay;
      r_rdata  <= '0;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rresp  <= w_rresp;
      r_rdata  <= w_rd_data;
    end else if (w_r_hs) begin
      r_rvalid <= 1'b0;
    end
  end
endmodule

// File: doc/axi_lite_reg_bank.md
Name: axi_lite_reg_bank

Overview:
- Parametrised AXI-Lite slave register bank, next generation of the simple AXI-Lite register bridge.
- Captures AW and W independently with real valid/ready backpressure, and supports WSTRB byte enables.
- Provides per-register read-only status slots, per-register write strobes to fabric logic, and out-of-range address handling.
- Sits between the AXI-Lite interconnect and block control/status logic.

Parameters:
- ADDR_WIDTH, 8, AXI address width; register index = addr[ADDR_WIDTH-1:2].
- DATA_WIDTH, 32, data width, multiple of 8; STRB = DATA_WIDTH/8.
- REG_COUNT, 8, number of registers, 1..2^(ADDR_WIDTH-2).
- RO_MASK, 0, REG_COUNT-bit mask; bit i set = register i is read-only, sourced from status_in.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axi_awaddr  in  ADDR_WIDTH  write address
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_wdata  in  DATA_WIDTH  write data
- s_axi_wstrb  in  STRB  byte enables
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_araddr  in  ADDR_WIDTH  read address
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_rdata  out  DATA_WIDTH  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready
- reg_out  out  REG_COUNT*DATA_WIDTH  flattened RW register contents; register i at [i*DATA_WIDTH +: DATA_WIDTH]
- status_in  in  REG_COUNT*DATA_WIDTH  flattened RO sources; only slices with RO_MASK set are used
- wr_pulse  out  REG_COUNT  one-cycle strobe per RW register on commit

Behaviour:
- Reset (rst=1 at posedge): all RW registers 0; aw_held=w_held=0; bvalid=rvalid=0; bresp=rresp=2'b00; rdata=0; wr_pulse=0. Reset mid-transaction discards held AW/W and pending B/R.
- Ready generation (registered):
  - awready = !aw_held && !bvalid.
  - wready = !w_held && !bvalid.
  - arready = !rvalid.
- Write path:
  - AW handshake latches awaddr and sets aw_held. W handshake latches wdata/wstrb and sets w_held. Either may arrive first or both in the same cycle.
  - Commit happens at the first posedge with aw_held && w_held && !bvalid. On that edge: byte lane k written iff wstrb[k]; bvalid<=1; held flags cleared; wr_pulse[idx]<=1 for exactly one cycle, RW in-range registers only.
  - bvalid holds with bresp stable until the bready handshake. New AW/W are accepted only after bvalid clears.
  - Minimum latency: bvalid is high in the second cycle after a same-cycle AW+W handshake.
  - wstrb=0 commits with OKAY, changes no data, and still pulses wr_pulse.
- Read path:
  - AR handshake at edge N registers rdata/rresp and sets rvalid at edge N.
  - rvalid and rdata hold until the rready handshake. Next arready follows in the cycle after rvalid clears.
  - Read data source: RW register → current value; RO register → status_in slice sampled at the AR edge.
- Simultaneous read and write commit to the same register on the same edge: read returns the pre-write value.
- Read and write paths are independent; no ordering between them.
- Address low bits [1:0] are ignored.

Optional Feature:
AXI_LITE_ERR_EN
- Defined:
  - Out-of-range index (>= REG_COUNT): writes are discarded with bresp=2'b11 (DECERR); reads return rdata=0, rresp=2'b11.
  - Write to an RO register: data discarded, bresp=2'b10 (SLVERR), no wr_pulse.
- Undefined: all of the above return 2'b00 (OKAY), writes are silently discarded, and out-of-range reads return 0.

Test Plan:
- Reset, then read idx 0..7 → rdata=0, rresp=00 for each; arready=1 while idle.
- AW(0x04) at cycle 2, W(0xDEADBEEF, strb=F) at cycle 5 → one commit; bvalid high from cycle 6; wr_pulse[1] high for one cycle; reg 1 = 0xDEADBEEF.
- Reg 2 = 0x11223344, then write 0xAABBCCDD with strb=0101 → reg 2 = 0x11BB33DD.
- Hold bready=0 for 10 cycles after a write → bvalid and bresp stable; awready=wready=0; a second AW is not accepted until after B completes.
- RO_MASK=0x80, status_in[7]=0x5A5A5A5A: read 0x1C → 0x5A5A5A5A. Write 0x1C → reg unchanged; bresp=10 with AXI_LITE_ERR_EN, 00 without.
- REG_COUNT=8, read 0x40 and write 0x40 → rresp/bresp=11 with macro, 00 without; rdata=0; no wr_pulse.
